alu_mul_seq: RTL
================

# alu_mul_seq

Sequential shift-and-add multiplier that owns no arithmetic of its own: it drives the datapath ALU's operand/function ports (a, b, s) and consumes its result and flag outputs (y, f), issuing add, shift and compare operations one per cycle. It sits beside the ALU as its initiator. Operands arrive on a valid/ready request port, and the low WIDTH bits of the product leave on a valid/ready response port.

## Interface
- WIDTH, 32, operand/product width; must match the ALU's WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request ready; high only in IDLE.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- out_valid  out  1  product valid; held until accepted.
- out_ready  in  1  product accepted.
- out_p  out  WIDTH  product, low WIDTH bits.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_s  out  3  ALU function select.
- alu_y  in  WIDTH  ALU result.
- alu_f  in  3  ALU flags; only bit 0 is used (a==b, valid when s=3'o0).

## Operation
- Internal registers:
  - mcand (WIDTH)
  - mplr (WIDTH)
  - acc (WIDTH)
  - cnt (clog2(WIDTH)+1 bits)
  - state
- State IDLE:
  - in_ready=1.
  - On in_valid: mcand<=in_a, mplr<=in_b, acc<=0, cnt<=0, go to TEST.
- State TEST:
  - Drives alu_a=mplr, alu_b=0, alu_s=3'o0 (SUB).
  - Exit to DONE if cnt==WIDTH, or if alu_f[0]==1 and EARLY_EXIT is enabled.
  - Otherwise go to ADD when mplr[0]==1, else to SHL.
- State ADD:
  - Drives alu_a=acc, alu_b=mcand, alu_s=3'o1.
  - acc<=alu_y; go to SHL.
- State SHL:
  - Drives alu_a=mcand, alu_b=1, alu_s=3'o6.
  - mcand<=alu_y; go to SHR.
- State SHR:
  - Drives alu_a=mplr, alu_b=1, alu_s=3'o5.
  - mplr<=alu_y, cnt<=cnt+1; go to TEST.
- State DONE:
  - out_valid=1, out_p=acc.
  - On out_ready go to IDLE.
- alu_a/alu_b/alu_s are decoded combinationally from state and registers. In IDLE and DONE they are all zero.
- ALU results are captured at the clock edge ending the state that issued the operation.
- Arithmetic wraps modulo 2^WIDTH; overflow is silently discarded. The operation is the same for signed and unsigned operands (low half only).
- in_valid is ignored outside IDLE; no request queuing.
- out_p is stable while out_valid is held.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - out_p=0
  - alu_a=0, alu_b=0, alu_s=0
  - acc=0, mcand=0, mplr=0, cnt=0
- rst mid-operation aborts immediately: the next cycle is IDLE and the product is lost.
- rst wins over any simultaneous handshake.
- Iteration cost: 3 cycles, or 4 when the current mplr bit is 1.
- Latency (accept edge to first out_valid cycle):
  - Without early exit: 3·WIDTH + popcount(in_b) + 1.
  - With early exit: 3·k + popcount(in_b) + 1, where k = index of the highest set bit of in_b plus 1 (k=0 for in_b=0).
- Earliest next accept is the cycle after the out_valid/out_ready handshake. There is no DONE→TEST bypass.

## Configuration
- MUL_EARLY_EXIT_EN defined: TEST also exits when the ALU reports mplr==0.
- MUL_EARLY_EXIT_EN undefined:
  - alu_f[0] is ignored.
  - Exactly WIDTH iterations always run; latency is data-dependent only through popcount.
  - TEST still drives the SUB so that the ALU port activity is identical.

## Structure
- Shared package holds:
  - ALU function codes: ALU_SUB=3'o0, ALU_ADD=3'o1, ALU_AND=3'o2, ALU_OR=3'o3, ALU_XOR=3'o4, ALU_SRL=3'o5, ALU_SLL=3'o6, ALU_SRA=3'o7.
  - Flag bit indices: FLAG_EQ=0, FLAG_LT=1, FLAG_LTU=2.
  - The mul state encoding.
- No sub-module: the ALU stays external. The bench and top level instantiate the ALU and connect the ALU ports.

## Test plan
- in_a=6, in_b=5, out_ready=1 -> out_p=30.
  - Early exit: out_valid 12 cycles after accept.
  - Without early exit: out_valid 99 cycles after accept.
- in_a=0x12345678, in_b=0 -> out_p=0.
  - Early exit: 1 cycle after accept.
  - Without early exit: 97 cycles after accept.
- in_a=0xFFFFFFFF, in_b=0xFFFFFFFF -> out_p=0x00000001, in both modes after 129 cycles.
- in_a=0x80000000, in_b=2 -> out_p=0 (wrap).
  - Check the alu_s sequence TEST/SHL/SHR then TEST/ADD/SHL/SHR: 0,6,5,0,1,6,5,…
- out_ready held low for 10 cycles in DONE -> out_valid and out_p stay stable, in_ready stays 0, and a new in_valid is ignored. Releasing out_ready returns the block to IDLE with in_ready=1.
- rst asserted 20 cycles into an operation -> next cycle: IDLE, in_ready=1, out_valid=0, ALU ports zero. A following in_a=7, in_b=3 produces 21.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: shared definitions for the sequential multiplier.
//   - ALU function select codes driven on alu_s
//   - ALU flag bit indices read from alu_f
//   - multiplier FSM state encoding
package alu_mul_seq_pkg;

  localparam logic [2:0] ALU_SUB = 3'o0;
  localparam logic [2:0] ALU_ADD = 3'o1;
  localparam logic [2:0] ALU_AND = 3'o2;
  localparam logic [2:0] ALU_OR  = 3'o3;
  localparam logic [2:0] ALU_XOR = 3'o4;
  localparam logic [2:0] ALU_SRL = 3'o5;
  localparam logic [2:0] ALU_SLL = 3'o6;
  localparam logic [2:0] ALU_SRA = 3'o7;

  localparam int FLAG_EQ  = 0;
  localparam int FLAG_LT  = 1;
  localparam int FLAG_LTU = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TEST = 3'd1,
    S_ADD  = 3'd2,
    S_SHL  = 3'd3,
    S_SHR  = 3'd4,
    S_DONE = 3'd5
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier that borrows an external ALU for
// all arithmetic. One ALU operation is issued per cycle and its result is
// captured at the edge that ends the issuing state.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (ready only in IDLE)
//   in_a, in_b            multiplicand / multiplier
//   out_valid/out_ready   response handshake (valid held until accepted)
//   out_p                 low WIDTH bits of the product
//   alu_a, alu_b, alu_s   ALU operands and function select
//   alu_y, alu_f          ALU result and flags (only the EQ flag is used)
//
// Build option: define MUL_EARLY_EXIT_EN to leave the loop as soon as the
// ALU reports the remaining multiplier is zero. Without it, WIDTH
// iterations always run and alu_f is ignored.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [2:0]       alu_f
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  mul_state_t       state, state_nxt;
  logic [WIDTH-1:0] mcand, mplr, acc;
  logic [CW-1:0]    cnt;
  logic             loop_done;

  // Only FLAG_EQ is consulted, and only in the early-exit build.
  logic unused_flags;
  assign unused_flags = ^alu_f;

  // TEST compares mplr against zero through the ALU; the flag only
  // matters when early exit is compiled in.
  assign loop_done = (cnt == CW'(WIDTH)) || (EARLY_EXIT && alu_f[FLAG_EQ]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_TEST;
      S_TEST: begin
        if (loop_done)    state_nxt = S_DONE;
        else if (mplr[0]) state_nxt = S_ADD;
        else              state_nxt = S_SHL;
      end
      S_ADD:  state_nxt = S_SHL;
      S_SHL:  state_nxt = S_SHR;
      S_SHR:  state_nxt = S_TEST;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshake and ALU drive decoded from state and registers
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    out_p     = (state == S_DONE) ? acc : '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = ALU_SUB;
    case (state)
      S_TEST: begin alu_a = mplr;  alu_b = '0;          alu_s = ALU_SUB; end
      S_ADD:  begin alu_a = acc;   alu_b = mcand;       alu_s = ALU_ADD; end
      S_SHL:  begin alu_a = mcand; alu_b = WIDTH'(1);   alu_s = ALU_SLL; end
      S_SHR:  begin alu_a = mplr;  alu_b = WIDTH'(1);   alu_s = ALU_SRL; end
      default: ;
    endcase
  end

  // Datapath registers: load on accept, capture ALU result per state
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          mcand <= in_a;
          mplr  <= in_b;
          acc   <= '0;
          cnt   <= '0;
        end
        S_ADD: acc   <= alu_y;
        S_SHL: mcand <= alu_y;
        S_SHR: begin
          mplr <= alu_y;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
